// File: rtl/gcd_operand_bank.sv
// gcd_operand_bank: operand bank running subtract-based Euclid GCD, valid/ready in and out.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a_in/b_in accept an operand pair in IDLE;
// out_valid/out_ready with gcd_out/zero_err present the result in DONE; busy is high while iterating;
// iter_count (only when GCD_ITER_COUNT_EN is defined) reports the subtraction steps of the last operation.
module gcd_operand_bank #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err,
  output logic             busy
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CNT_W-1:0] iter_count
`endif
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic zero_err_q, zero_err_d;
  logic a_z, b_z;
  assign a_z = ~|a_q;
  assign b_z = ~|b_q;
  assign in_ready = state_q == IDLE;
  assign busy = state_q == ITER;
  assign out_valid = state_q == DONE;
  assign gcd_out = gcd_q;
  assign zero_err = zero_err_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    gcd_d = gcd_q;
    zero_err_d = zero_err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a_in;
        b_d = b_in;
        state_d = ITER;
      end
      ITER: if (a_z || b_z || a_q == b_q) begin
        gcd_d = a_q | b_q;
        zero_err_d = a_z && b_z;
        state_d = DONE;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else begin
        b_d = b_q - a_q;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      gcd_q <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      gcd_q <= gcd_d;
      zero_err_q <= zero_err_d;
    end
  end
`ifdef GCD_ITER_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, step;
  assign accept = in_ready && in_valid;
  assign step = busy && !a_z && !b_z && a_q != b_q;
  assign iter_count = cnt_q;
  // saturate rather than wrap on very long runs
  always_comb cnt_d = accept ? '0 : (step && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_gcd_operand_bank.sv
// tb_gcd_operand_bank: directed self-checking bench for gcd_operand_bank (WIDTH=16 and WIDTH=8 instances).
module tb_gcd_operand_bank;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] a_in = '0, b_in = '0;
  logic in_ready, out_valid, zero_err, busy;
  logic [15:0] gcd_out;
  logic in_valid_8 = 1'b0, out_ready_8 = 1'b1;
  logic [7:0] a_in_8 = '0, b_in_8 = '0;
  logic in_ready_8, out_valid_8, zero_err_8, busy_8;
  logic [7:0] gcd_out_8;
  int checks = 0, errors = 0;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_count, iter_count_8;
`endif
  gcd_operand_bank #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .gcd_out(gcd_out), .zero_err(zero_err), .busy(busy)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(iter_count)
`endif
  );
  gcd_operand_bank #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .a_in(a_in_8), .b_in(b_in_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .gcd_out(gcd_out_8), .zero_err(zero_err_8), .busy(busy_8)
`ifdef GCD_ITER_COUNT_EN
    , .iter_count(iter_count_8)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int edges, input logic [15:0] g,
                     input logic z, input int cnt, input string tag);
    int n;
    @(negedge clk);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    n = 1;
    while (!out_valid && n < 600) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_latency"}, n, edges);
    chk({tag, "_gcd"}, gcd_out, g);
    chk({tag, "_zero_err"}, zero_err, z);
`ifdef GCD_ITER_COUNT_EN
    chk({tag, "_iter_count"}, iter_count, cnt);
`else
    if (cnt < 0) $display("cnt %0d", cnt);
`endif
    if (out_ready) begin
      @(posedge clk);
      #1 chk({tag, "_in_ready_after"}, in_ready, 1);
      chk({tag, "_out_valid_after"}, out_valid, 0);
    end
  endtask
  initial begin
    int n;
    logic [15:0] ta [5] = '{16'd48, 16'd30, 16'd12, 16'd12, 16'd6};
    logic [15:0] tb [5] = '{16'd18, 16'd18, 16'd18, 16'd6, 16'd6};
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gcd", gcd_out, 0);
    chk("rst_zero_err", zero_err, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("rst_iter_count", iter_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_in = 16'd48;
    b_in = 16'd18;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk($sformatf("trace_a%0d", k), dut.a_q, ta[k]);
      chk($sformatf("trace_b%0d", k), dut.b_q, tb[k]);
      chk($sformatf("trace_busy%0d", k), busy, 1);
      chk($sformatf("trace_ov%0d", k), out_valid, 0);
    end
    @(posedge clk);
    #1 chk("g48_out_valid", out_valid, 1);
    chk("g48_gcd", gcd_out, 6);
    chk("g48_zero_err", zero_err, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("g48_iter_count", iter_count, 4);
`endif
    @(posedge clk);
    #1 chk("g48_in_ready_after", in_ready, 1);
    run(16'd7, 16'd7, 2, 16'd7, 1'b0, 0, "g77");
    run(16'd0, 16'd9, 2, 16'd9, 1'b0, 0, "g09");
    run(16'd0, 16'd0, 2, 16'd0, 1'b1, 0, "g00");
    run(16'd9, 16'd0, 2, 16'd9, 1'b0, 0, "g90");
    @(negedge clk);
    a_in_8 = 8'd255;
    b_in_8 = 8'd1;
    in_valid_8 = 1'b1;
    @(posedge clk);
    #1 in_valid_8 = 1'b0;
    n = 1;
    while (!out_valid_8 && n < 600) begin
      @(posedge clk);
      #1 n++;
    end
    chk("w8_latency", n, 256);
    chk("w8_gcd", gcd_out_8, 1);
    chk("w8_zero_err", zero_err_8, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("w8_iter_count", iter_count_8, 254);
`endif
    out_ready = 1'b0;
    run(16'd12, 16'd8, 4, 16'd4, 1'b0, 2, "bp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k == 3;
      a_in = 16'd30;
      b_in = 16'd20;
      chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
      chk($sformatf("bp_out_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_gcd%0d", k), gcd_out, 4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    @(negedge clk);
    a_in = 16'd100;
    b_in = 16'd75;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3 chk("ar_busy_before", busy, 1);
    rst = 1'b1;
    #1 chk("ar_busy", busy, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_gcd", gcd_out, 0);
    chk("ar_zero_err", zero_err, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("ar_iter_count", iter_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run(16'd21, 16'd14, 4, 16'd7, 1'b0, 2, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
